// File: rtl/shared_resource_arbiter_if.sv
// Handshake bundle between the two pipeline requesters, the shared doubling
// resource, and the arbiter that sits in front of it.
interface shared_resource_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;
  logic [1:0]        req_stall;
  logic [1:0]        res_in_valid;
  logic [DATA_W-1:0] res_in_data;
  logic [1:0]        res_out_valid;
  logic [DATA_W-1:0] res_out_data;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data0;
  logic [DATA_W-1:0] rsp_data1;
  logic              proto_err;

  modport slave (
    input  req_valid, req_data0, req_data1, res_out_valid, res_out_data,
    output req_stall, res_in_valid, res_in_data, rsp_valid, rsp_data0,
           rsp_data1, proto_err
  );

  modport master (
    output req_valid, req_data0, req_data1, res_out_valid, res_out_data,
    input  req_stall, res_in_valid, res_in_data, rsp_valid, rsp_data0,
           rsp_data1, proto_err
  );
endinterface

// File: rtl/shared_resource_arbiter.sv
// Round-robin front end for the shared doubling resource: issues one tagged
// operand per cycle, routes tagged results back, and tracks per-requester credits.
module shared_resource_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input logic                     clk,
  input logic                     reset,
  shared_resource_arbiter_if.slave bus
);

  localparam int                CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [2];
  logic             last_grant;
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             ret_legal;
  logic [1:0]       ret_dec;

  always_comb begin
    eligible  = 2'b00;
    grant     = 2'b00;
    ret_legal = 1'b1;
    ret_dec   = 2'b00;

    eligible[0] = bus.req_valid[0] & (cnt[0] != CNT_MAX);
    eligible[1] = bus.req_valid[1] & (cnt[1] != CNT_MAX);

    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase

    // A return is only legal if it is one-hot and its requester has credit out.
    ret_legal = (bus.res_out_valid != 2'b11)
              && !(bus.res_out_valid[0] && (cnt[0] == '0))
              && !(bus.res_out_valid[1] && (cnt[1] == '0));
    ret_dec   = ret_legal ? bus.res_out_valid : 2'b00;
  end

  assign bus.req_stall = bus.req_valid & ~grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt[0]           <= '0;
      cnt[1]           <= '0;
      last_grant       <= 1'b1;
      bus.res_in_valid <= 2'b00;
      bus.res_in_data  <= '0;
      bus.rsp_valid    <= 2'b00;
      bus.rsp_data0    <= '0;
      bus.rsp_data1    <= '0;
      bus.proto_err    <= 1'b0;
    end else begin
      bus.res_in_valid <= grant;
      if (grant[0]) begin
        bus.res_in_data <= bus.req_data0;
      end else if (grant[1]) begin
        bus.res_in_data <= bus.req_data1;
      end

      if (grant != 2'b00) begin
        last_grant <= grant[1];
      end

      // Grant and legal return in the same cycle cancel out.
      for (int i = 0; i < 2; i++) begin
        case ({grant[i], ret_dec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_ONE;
          2'b01:   cnt[i] <= cnt[i] - CNT_ONE;
          default: cnt[i] <= cnt[i];
        endcase
      end

      bus.rsp_valid <= ret_dec;
      if (bus.res_out_valid[0]) begin
        bus.rsp_data0 <= bus.res_out_data;
      end
      if (bus.res_out_valid[1]) begin
        bus.rsp_data1 <= bus.res_out_data;
      end

      bus.proto_err <= bus.proto_err | ~ret_legal;
    end
  end

endmodule
